// File: rtl/iru_rotate_ctrl.sv
// iru_rotate_ctrl
// Buffers one 20x20 8-bit image, then streams it back out in raster order
// while an external compute unit maps each destination coordinate to a
// source coordinate (the rotation itself lives in that unit). This block
// only sequences angle capture, image load and the output stream with
// valid/ready back-pressure.
module iru_rotate_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        angle_valid,
  output logic        angle_ready,
  input  logic [35:0] angle,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pixel,
  output logic [35:0] comp_rnn_out,
  output logic [4:0]  comp_row_d,
  output logic [4:0]  comp_col_d,
  input  logic        comp_valid,
  input  logic [4:0]  comp_row_q,
  input  logic [4:0]  comp_col_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel,
  output logic        out_last
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2
  } state_t;

  localparam int unsigned NPIX     = 400;
  localparam logic [8:0]  LAST_IDX = 9'd399;
  localparam logic [4:0]  DIM_LAST = 5'd19;
  localparam logic [9:0]  NPIX_10  = 10'd400;

  // Source address row*20+col built from shifts; evaluated one bit wider than
  // the 9-bit buffer index so out-of-range coordinates cannot alias into it.
  function automatic logic [9:0] src_addr(input logic [4:0] row, input logic [4:0] col);
    logic [9:0] r10;
    r10 = {5'd0, row};
    return (r10 << 4) + (r10 << 2) + {5'd0, col};
  endfunction

  state_t      state_q, state_d;
  logic [35:0] angle_q, angle_d;
  logic [8:0]  load_idx_q, load_idx_d;
  logic [4:0]  row_cnt_q, row_cnt_d;
  logic [4:0]  col_cnt_q, col_cnt_d;
  logic        gen_active_q, gen_active_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_pixel_q, out_pixel_d;
  logic        out_last_q, out_last_d;
  logic        angle_ready_q, angle_ready_d;
  logic        in_ready_q, in_ready_d;

  logic [7:0]  buf_q [NPIX];

  logic        adv_s;
  logic        buf_we_s;
  logic [9:0]  src_addr_s;
  logic        fetch_ok_s;
  logic [8:0]  rd_idx_s;
  logic [7:0]  rd_pixel_s;
  logic [7:0]  fetch_pixel_s;
  logic        at_end_s;

  assign comp_rnn_out = angle_q;
  assign comp_row_d   = row_cnt_q;
  assign comp_col_d   = col_cnt_q;
  assign angle_ready  = angle_ready_q;
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pixel    = out_pixel_q;
  assign out_last     = out_last_q;

  // Buffer read path: only an in-range coordinate flagged valid reaches the array.
  always_comb begin
    src_addr_s = src_addr(comp_row_q, comp_col_q);
    fetch_ok_s = comp_valid && (src_addr_s < NPIX_10);
    if (fetch_ok_s) begin
      rd_idx_s = src_addr_s[8:0];
    end else begin
      rd_idx_s = 9'd0;
    end
    rd_pixel_s = buf_q[rd_idx_s];
    if (fetch_ok_s) begin
      fetch_pixel_s = rd_pixel_s;
    end else begin
      fetch_pixel_s = 8'h00;
    end
  end

  // Pixel store: one write per accepted input beat; contents are never reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[load_idx_q] <= in_pixel;
    end
  end

  // Next-state and next-output computation for the control FSM.
  always_comb begin
    state_d      = state_q;
    angle_d      = angle_q;
    load_idx_d   = load_idx_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    gen_active_d = gen_active_q;
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    out_last_d   = out_last_q;
    adv_s        = !out_valid_q || out_ready;
    buf_we_s     = rst_n && in_ready_q && in_valid;
    at_end_s     = (row_cnt_q == DIM_LAST) && (col_cnt_q == DIM_LAST);

    case (state_q)
      ST_IDLE: begin
        if (angle_valid && angle_ready_q) begin
          angle_d = angle;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          if (load_idx_q == LAST_IDX) begin
            load_idx_d   = 9'd0;
            row_cnt_d    = 5'd0;
            col_cnt_d    = 5'd0;
            gen_active_d = 1'b1;
            state_d      = ST_ROTATE;
          end else begin
            load_idx_d = load_idx_q + 9'd1;
          end
        end else begin
          load_idx_d = load_idx_q;
        end
      end

      ST_ROTATE: begin
        if (out_valid_q && out_ready && out_last_q) begin
          // Final pixel handed off: close the frame.
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (adv_s) begin
          if (gen_active_q) begin
            out_pixel_d = fetch_pixel_s;
            out_valid_d = 1'b1;
            out_last_d  = at_end_s;
            if (col_cnt_q == DIM_LAST) begin
              col_cnt_d = 5'd0;
              if (row_cnt_q == DIM_LAST) begin
                row_cnt_d    = 5'd0;
                gen_active_d = 1'b0;
              end else begin
                row_cnt_d = row_cnt_q + 5'd1;
              end
            end else begin
              col_cnt_d = col_cnt_q + 5'd1;
            end
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end else begin
          // Stalled by the consumer: everything holds.
          out_valid_d = out_valid_q;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d      = ST_IDLE;
        load_idx_d   = 9'd0;
        row_cnt_d    = 5'd0;
        col_cnt_d    = 5'd0;
        gen_active_d = 1'b0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
      end
    endcase

    angle_ready_d = (state_d == ST_IDLE);
    in_ready_d    = (state_d == ST_LOAD);
  end

  // Control state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      angle_q       <= 36'd0;
      load_idx_q    <= 9'd0;
      row_cnt_q     <= 5'd0;
      col_cnt_q     <= 5'd0;
      gen_active_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_pixel_q   <= 8'h00;
      out_last_q    <= 1'b0;
      angle_ready_q <= 1'b1;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      load_idx_q    <= load_idx_d;
      row_cnt_q     <= row_cnt_d;
      col_cnt_q     <= col_cnt_d;
      gen_active_q  <= gen_active_d;
      out_valid_q   <= out_valid_d;
      out_pixel_q   <= out_pixel_d;
      out_last_q    <= out_last_d;
      angle_ready_q <= angle_ready_d;
      in_ready_q    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_iru_rotate_ctrl.sv
// Self-checking bench for iru_rotate_ctrl: stub compute units, random images,
// varied back-pressure, resets mid-frame and held-high valids.
module tb_iru_rotate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        angle_valid;
  logic        angle_ready;
  logic [35:0] angle;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic [35:0] comp_rnn_out;
  logic [4:0]  comp_row_d;
  logic [4:0]  comp_col_d;
  logic        comp_valid;
  logic [4:0]  comp_row_q;
  logic [4:0]  comp_col_q;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic        out_last;

  int vectors = 0;
  int miscompares = 0;
  int stub_mode = 0;

  logic [7:0] img [400];
  logic [7:0] got_pix [400];
  logic       got_last [400];

  always #5 clk = ~clk;

  iru_rotate_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .angle_valid(angle_valid), .angle_ready(angle_ready), .angle(angle),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .comp_rnn_out(comp_rnn_out), .comp_row_d(comp_row_d), .comp_col_d(comp_col_d),
    .comp_valid(comp_valid), .comp_row_q(comp_row_q), .comp_col_q(comp_col_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
  );

  // Compute-unit stub: 0 identity, 1 180-degree, 2 never valid, 3 transpose.
  always_comb begin
    comp_valid = 1'b1;
    comp_row_q = comp_row_d;
    comp_col_q = comp_col_d;
    case (stub_mode)
      1: begin
        comp_row_q = 5'(5'd20 - comp_row_d);
        comp_col_q = 5'(5'd20 - comp_col_d);
        comp_valid = (comp_row_d != 5'd0) && (comp_col_d != 5'd0);
      end
      2: comp_valid = 1'b0;
      3: begin
        comp_row_q = comp_col_d;
        comp_col_q = comp_row_d;
      end
      default: ;
    endcase
  end

  // Reference: destination (r,c) takes source (sr,sc) when the mapping is valid, else 0.
  function automatic logic [7:0] model_pix(input int mode, input int k);
    int r, c, sr, sc;
    bit v;
    r = k / 20; c = k % 20; sr = r; sc = c; v = 1'b1;
    case (mode)
      1: begin sr = 20 - r; sc = 20 - c; v = (r != 0) && (c != 0); end
      2: v = 1'b0;
      3: begin sr = c; sc = r; end
      default: ;
    endcase
    if (v) return img[sr * 20 + sc];
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_angle_ready", 64'(angle_ready), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pixel", 64'(out_pixel), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_comp_rnn_out", 64'(comp_rnn_out), 64'd0);
    chk("rst_comp_row_d", 64'(comp_row_d), 64'd0);
    chk("rst_comp_col_d", 64'(comp_col_d), 64'd0);
  endtask

  task automatic pulse_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic send_angle(input logic [35:0] a, input bit keep);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    angle = a; angle_valid = 1'b1;
    while (!hs && t < 200) begin
      @(negedge clk); hs = angle_ready;
      @(posedge clk); #1; t++;
    end
    chk("angle_handshake", 64'(hs), 64'd1);
    if (!keep) angle_valid = 1'b0;
    chk("angle_latched", 64'(comp_rnn_out), 64'(a));
    chk("load_angle_ready", 64'(angle_ready), 64'd0);
    chk("load_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic load_frame(input int n, input bit gaps, input bit keep);
    bit hs;
    int t;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_pixel = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_pixel = img[k];
      hs = 1'b0; t = 0;
      while (!hs && t < 200) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1; t++;
      end
      if (!hs) begin
        chk("load_handshake", 64'(hs), 64'd1);
        return;
      end
    end
    if (keep) in_pixel = 8'hEE;
    else in_valid = 1'b0;
  endtask

  // Drains one frame under a ready pattern and checks it against the model.
  task automatic collect(input int smode, input int rmode, input logic [35:0] exp_ang);
    int n, cyc, first, lastc, bad_stall, bad_rdy, bad_ang;
    bit pstall;
    logic [7:0] ppix;
    logic plast;
    n = 0; cyc = 0; first = -1; lastc = -1;
    bad_stall = 0; bad_rdy = 0; bad_ang = 0; pstall = 1'b0; ppix = 8'h00; plast = 1'b0;
    for (int k = 0; k < 400; k++) begin got_pix[k] = 'x; got_last[k] = 1'bx; end
    while (n < 400 && cyc < 3000) begin
      case (rmode)
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (pstall && (out_valid !== 1'b1 || out_pixel !== ppix || out_last !== plast)) bad_stall++;
      pstall = out_valid && !out_ready; ppix = out_pixel; plast = out_last;
      if (in_ready || angle_ready) bad_rdy++;
      if (comp_rnn_out !== exp_ang) bad_ang++;
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        got_pix[n] = out_pixel; got_last[n] = out_last; n++; lastc = cyc;
      end
      @(posedge clk); #1; cyc++;
    end
    chk("rx_count", 64'(n), 64'd400);
    chk("first_valid_latency", 64'(first), 64'd1);
    if (rmode == 0) chk("consecutive_400", 64'(lastc - first), 64'd399);
    chk("stall_hold", 64'(bad_stall), 64'd0);
    chk("ready_during_rotate", 64'(bad_rdy), 64'd0);
    chk("angle_stable", 64'(bad_ang), 64'd0);
    for (int k = 0; k < 400; k++) begin
      chk($sformatf("pix%0d", k), 64'({got_last[k], got_pix[k]}),
          64'({(k == 399), model_pix(smode, k)}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_angle_ready", 64'(angle_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic fill_img(input bit idx_img);
    for (int k = 0; k < 400; k++) img[k] = idx_img ? 8'(k) : 8'($urandom);
  endtask

  function automatic logic [35:0] rand_angle();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  task automatic run_frame(input int smode, input int rmode, input bit idx_img, input bit gaps);
    logic [35:0] a;
    stub_mode = smode;
    fill_img(idx_img);
    a = rand_angle();
    send_angle(a, 1'b0);
    load_frame(400, gaps, 1'b0);
    collect(smode, rmode, a);
  endtask

  initial begin
    logic [35:0] a1, a2, a3;
    int vbad;
    rst_n = 1'b0; angle_valid = 1'b0; angle = 36'd0;
    in_valid = 1'b0; in_pixel = 8'h00; out_ready = 1'b1;

    // Power-on reset.
    @(posedge clk); #1;
    pulse_reset(3);
    check_reset_outputs();

    // Identity, idx-coded image, always ready.
    run_frame(0, 0, 1'b1, 1'b0);

    // 180-degree, random image; spot checks on border and one interior point.
    run_frame(1, 0, 1'b0, 1'b0);
    chk("rot180_5_7", 64'(got_pix[5 * 20 + 7]), 64'(img[15 * 20 + 13]));
    chk("rot180_row0", 64'(got_pix[0 * 20 + 3]), 64'd0);
    chk("rot180_col0", 64'(got_pix[9 * 20 + 0]), 64'd0);

    // Never-valid mapping, random ready.
    run_frame(2, 2, 1'b0, 1'b1);

    // Identity with 1,0,0,1 ready pattern and input gaps.
    run_frame(0, 1, 1'b1, 1'b1);

    // Transpose, random image, random ready.
    run_frame(3, 2, 1'b0, 1'b1);

    // Reset after 200 load accepts, then a full frame.
    stub_mode = 0;
    fill_img(1'b0);
    send_angle(rand_angle(), 1'b0);
    load_frame(200, 1'b0, 1'b0);
    pulse_reset(1);
    check_reset_outputs();
    vbad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); if (out_valid) vbad++;
      @(posedge clk); #1;
    end
    chk("no_valid_after_load_reset", 64'(vbad), 64'd0);
    run_frame(0, 0, 1'b1, 1'b0);

    // Reset mid-ROTATE abandons the frame.
    stub_mode = 0;
    fill_img(1'b0);
    send_angle(rand_angle(), 1'b0);
    load_frame(400, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; end
    pulse_reset(1);
    check_reset_outputs();
    vbad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); if (out_valid) vbad++;
      @(posedge clk); #1;
    end
    chk("no_valid_after_rotate_reset", 64'(vbad), 64'd0);
    run_frame(3, 1, 1'b0, 1'b0);

    // angle_valid and in_valid held high across two back-to-back frames.
    stub_mode = 0;
    a1 = rand_angle(); a2 = rand_angle(); a3 = rand_angle();
    in_valid = 1'b1; in_pixel = 8'hEE;
    fill_img(1'b0);
    send_angle(a1, 1'b1);
    angle = a2;
    load_frame(400, 1'b0, 1'b1);
    collect(0, 0, a1);
    fill_img(1'b0);
    load_frame(400, 1'b0, 1'b1);
    chk("hold_second_angle", 64'(comp_rnn_out), 64'(a2));
    angle = a3;
    collect(0, 2, a2);
    angle_valid = 1'b0; in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
